aes_encrypt_iter: RTL and testbench

Iterative AES-128 encryption core: the forward (cipher) counterpart of the inverse-round decryption path. It accepts one plaintext block and one cipher key over a valid/ready handshake and applies the initial AddRoundKey plus ten forward rounds, one round per clock. Round keys are expanded on the fly. The ciphertext is returned over a second valid/ready handshake. It sits between the block-data source and the key expander, and shares byte ordering with the decryption path, so encrypt/decrypt loopback needs no reformatting.

---
 rtl/aes_encrypt_iter.sv | 187 ++++++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_encrypt_iter
// Brief    : Iterative AES-128 encryption, one round per clock, on-the-fly
//            key expansion, valid/ready in and out. Optional macro
//            AES_ENC_LAST_KEY_EN exposes the round-10 key on last_key.
// Revision : 1.0 - initial release
// ============================================================================
module aes_encrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
`ifdef AES_ENC_LAST_KEY_EN
    ,
    output logic [127:0] last_key
`endif
);

    localparam logic [3:0] c_LAST_RND = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Forward S-box as multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0]   w_sb  [16];
    logic [7:0]   w_sr  [16];
    logic [7:0]   w_ksb [4];
    logic [127:0] w_sr_flat;
    logic [127:0] w_mc_flat;
    logic [127:0] w_key_next;
    logic [127:0] w_round;
    logic [31:0]  w_k0;
    logic [31:0]  w_k1;
    logic [31:0]  w_k2;
    logic [31:0]  w_k3;

    for (genvar i = 0; i < 16; i++) begin : g_sub_state
        assign w_sb[i] = sbox(r_state[127-8*i -: 8]);
    end

    // Key S-boxes look at w3; byte j of w3 sits at bits [31-8j -: 8].
    for (genvar j = 0; j < 4; j++) begin : g_sub_key
        assign w_ksb[j] = sbox(r_key[31-8*j -: 8]);
    end

    // Byte index is row + 4*col; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign w_sr[r+4*c] = w_sb[r+4*((c+r)%4)];
        end
    end

    always_comb begin
        w_sr_flat = '0;
        w_mc_flat = '0;
        for (int c = 0; c < 4; c++) begin
            w_sr_flat[127-32*c -: 32] = {w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]};
            w_mc_flat[127-32*c -: 32] = {
                xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3],
                w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3],
                w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3],
                xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3])
            };
        end
    end

    assign w_k0       = r_key[127:96] ^ {w_ksb[1] ^ rcon(r_rnd), w_ksb[2], w_ksb[3], w_ksb[0]};
    assign w_k1       = r_key[95:64] ^ w_k0;
    assign w_k2       = r_key[63:32] ^ w_k1;
    assign w_k3       = r_key[31:0]  ^ w_k2;
    assign w_key_next = {w_k0, w_k1, w_k2, w_k3};
    assign w_round    = ((r_rnd == c_LAST_RND) ? w_sr_flat : w_mc_flat) ^ w_key_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_rnd   <= '0;
        end else begin
            r_fsm <= w_fsm_next;
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= plaintext ^ key;
                        r_key   <= key;
                        r_rnd   <= 4'd1;
                    end
                end
                ST_RUN: begin
                    r_state <= w_round;
                    r_key   <= w_key_next;
                    r_rnd   <= r_rnd + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_next = ST_RUN;
            end
            ST_RUN: begin
                if (r_rnd == c_LAST_RND) w_fsm_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_next = ST_IDLE;
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    assign ciphertext = out_valid ? r_state : '0;

`ifdef AES_ENC_LAST_KEY_EN
    assign last_key = out_valid ? r_key : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encrypt_iter
// Brief    : Self-checking bench for aes_encrypt_iter (FIPS-197 and random
//            vectors against a table-based reference, plus handshake corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext;
`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] last_key;
`endif

    int checks = 0;
    int errors = 0;
    int overlap_seen = 0;

    always #5 clk = ~clk;

    aes_encrypt_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
`ifdef AES_ENC_LAST_KEY_EN
        ,
        .last_key   (last_key)
`endif
    );

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] ct;
        logic [127:0] lk;
    } vec_t;

    logic [7:0] sb_tab [256];

    always @(negedge clk) if (in_ready && out_valid) overlap_seen++;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group with generator 3 to tabulate the S-box.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb_tab[0] = 8'h63;
    endtask

    function automatic logic [7:0] cmul(input int c, input logic [7:0] a);
        if (c == 1) return a;
        if (c == 2) return xt(a);
        return xt(a) ^ a;
    endfunction

    task automatic aes_ref(input logic [127:0] pt, input logic [127:0] k,
                           output logic [127:0] ct, output logic [127:0] lk);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        int          coef [4];
        coef = '{2, 3, 1, 1};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rd < 10) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        s[r+4*c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[r+4*c] = s[r+4*c] ^ cmul(coef[(j-r+4)%4], t[j+4*c]);
                    end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = s[r+4*c] ^ w[4*rd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        lk = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present a block at a negedge where the core is idle; returns at the
    // negedge after the accept edge with inputs scrambled.
    task automatic start_blk(input logic [127:0] pt, input logic [127:0] k, input logic ordy);
        plaintext = pt;
        key       = k;
        out_ready = ordy;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        plaintext = rnd128();
        key       = rnd128();
    endtask

    task automatic wait_out(inout int n);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ect, input logic [127:0] elk);
        int n;
        @(negedge clk);
        chk("idle_in_ready", {127'b0, in_ready}, 128'd1);
        start_blk(pt, k, 1'b1);
        n = 0;
        wait_out(n);
        chk("latency", n, 10);
        chk("ciphertext", ciphertext, ect);
        chk("busy_in_ready", {127'b0, in_ready}, 128'd0);
`ifdef AES_ENC_LAST_KEY_EN
        chk("last_key", last_key, elk);
`else
        if (elk === 128'hx) $display("note: unused expected key");
`endif
        @(negedge clk);
        chk("post_out_valid", {127'b0, out_valid}, 128'd0);
        chk("post_ciphertext", ciphertext, 128'd0);
        chk("post_in_ready", {127'b0, in_ready}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        logic [127:0] q_acc_dummy;
        int n;
        int acc [$];
        logic [127:0] outs [$];
        int stray;

        build_sbox();
        vecs[0] = '{C1_PT, C1_KEY, C1_CT, C1_LK};
        vecs[1] = '{B_PT, B_KEY, B_CT, B_LK};
        for (int i = 2; i < 8; i++) begin
            vecs[i].pt = rnd128();
            vecs[i].k  = rnd128();
            aes_ref(vecs[i].pt, vecs[i].k, vecs[i].ct, vecs[i].lk);
        end
        vecs[7].pt = '0;
        vecs[7].k  = '1;
        aes_ref(vecs[7].pt, vecs[7].k, vecs[7].ct, vecs[7].lk);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", {127'b0, in_ready}, 128'd1);
        chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
        chk("reset_ciphertext", ciphertext, 128'd0);
`ifdef AES_ENC_LAST_KEY_EN
        chk("reset_last_key", last_key, 128'd0);
`endif

        for (int i = 0; i < 8; i++) run_vec(vecs[i].pt, vecs[i].k, vecs[i].ct, vecs[i].lk);

        // Backpressure: result held for five cycles while out_ready is low.
        @(negedge clk);
        start_blk(C1_PT, C1_KEY, 1'b0);
        n = 0;
        wait_out(n);
        chk("bp_latency", n, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
            chk("bp_ciphertext", ciphertext, C1_CT);
            chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", {127'b0, in_ready}, 128'd1);
        chk("bp_release_out_valid", {127'b0, out_valid}, 128'd0);

        // Busy rejection: B offered during round 5 of a C.1 run.
        start_blk(C1_PT, C1_KEY, 1'b1);
        n = 0;
        repeat (4) begin @(negedge clk); n++; end
        plaintext = B_PT;
        key       = B_KEY;
        in_valid  = 1'b1;
        chk("busy_rej_in_ready", {127'b0, in_ready}, 128'd0);
        @(negedge clk);
        n++;
        in_valid = 1'b0;
        chk("busy_rej_in_ready2", {127'b0, in_ready}, 128'd0);
        wait_out(n);
        chk("busy_rej_latency", n, 10);
        chk("busy_rej_ciphertext", ciphertext, C1_CT);
        @(negedge clk);
        chk("busy_rej_idle", {127'b0, in_ready}, 128'd1);

        // Reset at round 6 abandons the block.
        start_blk(C1_PT, C1_KEY, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_mid_ciphertext", ciphertext, 128'd0);
        chk("rst_mid_in_ready", {127'b0, in_ready}, 128'd1);
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("rst_mid_no_output", stray, 0);
        run_vec(C1_PT, C1_KEY, C1_CT, C1_LK);

        // Back-to-back with in_valid held high.
        @(negedge clk);
        plaintext = C1_PT;
        key       = C1_KEY;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (out_valid) outs.push_back(ciphertext);
            if (in_ready && in_valid) acc.push_back(t);
            @(negedge clk);
            if (acc.size() == 1) begin
                plaintext = B_PT;
                key       = B_KEY;
            end
            if (acc.size() >= 2) in_valid = 1'b0;
        end
        chk("b2b_accept_count", acc.size(), 2);
        chk("b2b_output_count", outs.size(), 2);
        if (acc.size() >= 2) chk("b2b_accept_spacing", acc[1] - acc[0], 12);
        q_acc_dummy = (outs.size() > 0) ? outs[0] : 128'd0;
        chk("b2b_first_ct", q_acc_dummy, C1_CT);
        q_acc_dummy = (outs.size() > 1) ? outs[1] : 128'd0;
        chk("b2b_second_ct", q_acc_dummy, B_CT);

        chk("ready_valid_exclusive", overlap_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
